// File: rtl/sc_pkg.sv
// sc_pkg: shared constants, FSM state type and popcount helper for the SNG stage
package sc_pkg;
  localparam int NUM_LANES  = 8;
  localparam int WIDTH      = 8;
  localparam int STREAM_LEN = 256;
  localparam int BEATS      = STREAM_LEN / NUM_LANES;
  localparam int CNT_W      = $clog2(STREAM_LEN + 1);
  localparam int BEAT_W     = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_LANES; i++) popcount = popcount + CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/sc_lane_compare.sv
// sc_lane_compare: parallel operand-vs-random comparators, one stream bit per lane
module sc_lane_compare
  import sc_pkg::*;
(
  input  logic [WIDTH-1:0]     i_x,
  input  logic [WIDTH-1:0]     i_rand [0:NUM_LANES-1],
  output logic [NUM_LANES-1:0] o_bits
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign o_bits[i] = (i_x != '0) && (i_rand[i] <= i_x);
  end
endmodule

// File: rtl/sc_bitstream_gen.sv
// sc_bitstream_gen: converts one operand into a STREAM_LEN-bit stochastic stream, NUM_LANES bits per beat
module sc_bitstream_gen
  import sc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     rand_in [0:NUM_LANES-1],
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_value,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NUM_LANES-1:0] m_bits,
  output logic                 m_last,
  output logic                 done,
  output logic [CNT_W-1:0]     ones_count
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t              r_state;
  logic [WIDTH-1:0]    r_x;
  logic [BEAT_W-1:0]   r_beat;
  logic [CNT_W-1:0]    r_acc;
  logic [NUM_LANES-1:0] w_bits;
  logic                w_load;

  sc_lane_compare u_cmp (.i_x(r_x), .i_rand(rand_in), .o_bits(w_bits));

  assign s_ready = (r_state == IDLE);
  assign w_load  = !m_valid || m_ready;

  // operand capture, beat loading with backpressure, and completion reporting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_beat     <= '0;
      r_acc      <= '0;
      m_valid    <= 1'b0;
      m_bits     <= '0;
      m_last     <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (s_valid) begin
          r_x     <= s_value;
          r_beat  <= '0;
          r_acc   <= '0;
          r_state <= RUN;
        end
        RUN: if (w_load) begin
          m_bits  <= w_bits;
          m_valid <= 1'b1;
          m_last  <= (r_beat == LAST_BEAT);
          r_acc   <= r_acc + popcount(w_bits);
          r_beat  <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) r_state <= FLUSH;
        end
        FLUSH: if (m_valid && m_ready) begin
          m_valid    <= 1'b0;
          m_last     <= 1'b0;
          done       <= 1'b1;
          ones_count <= r_acc;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sc_bitstream_gen.md
# sc_bitstream_gen

Stochastic number generator (SNG) stage that sits directly downstream of the parallel 8-bit LFSR. It accepts one binary operand through a valid/ready handshake and compares that operand against the NUM_LANES random words the LFSR delivers every clock. It emits a parallel stochastic bitstream of STREAM_LEN bits, NUM_LANES bits per beat, with a ready/valid output and a last flag. On completion it reports the total ones count, so downstream stochastic arithmetic and the bench can check the encoded probability.

## Interface
- NUM_LANES, 8, random words consumed and stream bits produced per beat; matches the LFSR NUM_OUTPUTS.
- WIDTH, 8, operand and random-word width.
- STREAM_LEN, 256, bits per stream.
  - Must be a multiple of NUM_LANES and at least NUM_LANES.
  - BEATS = STREAM_LEN/NUM_LANES.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rand_in  in  WIDTH x [0:NUM_LANES-1]  unpacked random words, free-running from the LFSR.
- s_valid  in  1  operand valid.
- s_ready  out  1  block can accept an operand.
- s_value  in  WIDTH  operand x; encoded probability is x/255.
- m_valid  out  1  m_bits valid.
- m_ready  in  1  consumer accepts the beat.
- m_bits  out  NUM_LANES  stream bits; bit i comes from lane i.
- m_last  out  1  final beat of the stream.
- done  out  1  one-cycle pulse after the final beat is accepted.
- ones_count  out  $clog2(STREAM_LEN+1)  total ones in the stream; stable from the done pulse until the next operand is accepted.

## Operation
- The FSM has three states: IDLE, RUN, FLUSH.
- IDLE:
  - s_ready=1.
  - On s_valid, latch x=s_value, clear beat_cnt and the ones accumulator, then go to RUN.
- RUN:
  - s_ready=0.
  - Load a beat in every cycle where (!m_valid || m_ready). Loading a beat means:
    - m_bits[i] <= (x!=0) && (rand_in[i] <= x).
    - m_valid <= 1.
    - m_last <= (beat_cnt==BEATS-1).
    - accumulator += popcount of the loaded bits.
    - beat_cnt++.
  - Loading the final beat moves the FSM to FLUSH.
- FLUSH:
  - Hold the final beat.
  - On m_valid && m_ready: clear m_valid and m_last, pulse done, drive ones_count from the accumulator, go to IDLE.
- Comparison rule: x=0 gives all zeros; x=255 gives all ones. The zero random word is excluded by construction.
- Backpressure: while m_valid && !m_ready, m_bits and m_last hold stable. rand_in changes are ignored and no beat is consumed.
- s_valid while s_ready=0 is ignored; the operand is not queued.
- Accumulator width is $clog2(STREAM_LEN+1) and never wraps (maximum is STREAM_LEN).
- Reset, asserted at any time including mid-stream, forces:
  - state IDLE, s_ready=1;
  - m_valid=0, m_bits=0, m_last=0;
  - done=0, ones_count=0, beat_cnt=0.
  - A partial stream is discarded.

## Timing
- Operand handshake at edge 0 → RUN in cycle 1; the first beat is compared on cycle-1 rand_in and m_valid rises at edge 1.
- With m_ready held at 1: beats appear at edges 1..BEATS, m_last on beat BEATS, done at edge BEATS+1, s_ready=1 from edge BEATS+1.
- Throughput is one beat per cycle, with zero bubbles under continuous m_ready.
- All outputs are registered; there is no combinational path from inputs to outputs except s_ready, which is decoded from state.
- The earliest next operand is accepted in the same cycle done is high.

## Structure
- Shared package sc_pkg holds:
  - the state typedef (IDLE, RUN, FLUSH);
  - the localparams BEATS and CNT_W;
  - a popcount function for NUM_LANES bits.
- One sub-module, sc_lane_compare: purely combinational, NUM_LANES parallel (x!=0 && rand<=x) comparators producing NUM_LANES bits.
- The FSM, beat counter, output register and accumulator stay in the top module.

## Test plan
- All lanes of rand_in = 8'h80, x=8'h80, m_ready=1 → 32 beats of 8'hFF, m_last on beat 32, done at edge 33, ones_count=256.
- All lanes = 8'h80, x=8'h7F → 32 beats of 8'h00, ones_count=0.
- x=0 with any rand_in → all-zero stream, ones_count=0. x=255 with lanes at 8'hFF → ones_count=256.
- rand_in from a live parallel LFSR (seed 8'h01), x=8'h40, random m_ready stalls:
  - every beat matches a reference model fed the rand_in sampled at each load cycle;
  - m_bits is stable during stalls;
  - ones_count equals the model's sum.
- Back-to-back operands: present the next s_valid during done → accepted that cycle; first beat of the new stream follows one cycle later with no loss.
- Assert reset_n low mid-RUN at beat 10 → next cycle all outputs are zero and s_ready=1. After release, a new operand produces a full 32-beat stream.
